// File: rtl/snack_order_manager.sv
// Order front-end: assembles UART command packets, queues GO orders, dispatches them to the dispenser bank.
// Optional build macro ORDER_CHECKSUM_EN appends a trailing XOR checksum byte to every packet.
module snack_order_manager #(
  parameter int unsigned N_CH        = 5,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [7:0]                             rx_data,
  input  logic                                   rx_valid,
  input  logic [N_CH-1:0]                        disp_busy,
  output logic                                   disp_start,
  output logic [N_CH*CNT_W-1:0]                  disp_count,
  output logic                                   busy,
  output logic [$clog2(DEPTH+1)-1:0]             queue_level,
  output logic                                   queue_full,
  output logic [7:0]                             drop_cnt,
  output logic [7:0]                             err_cnt,
  output logic [8*((N_CH*CNT_W+8)/8)-1:0]        debug_command
);

  localparam int unsigned CW    = N_CH * CNT_W;
  localparam int unsigned BYTES = (CW + 8) / 8;
  localparam int unsigned PKT_W = 8 * BYTES;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
`ifdef ORDER_CHECKSUM_EN
  localparam int unsigned TOT   = BYTES + 1;
`else
  localparam int unsigned TOT   = BYTES;
`endif
  localparam int unsigned IDX_W = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {D_IDLE, D_START, D_SETTLE, D_RUN} d_state_t;

  d_state_t           state;
  logic               settle_cnt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_eff_c;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [PKT_W-1:0]   pkt_buf;
  logic [PKT_W-1:0]   pkt_next_c;
  logic               tmo_hit_c;
  logic               last_c;
  logic               pkt_done_c;
  logic               chk_bad_c;
  logic               go_c;
  logic               push_c;
  logic               pop_c;
  logic               drop_c;
  logic [LVL_W-1:0]   level_next_c;
  logic [CW-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
`ifdef ORDER_CHECKSUM_EN
  logic [7:0]         xor_acc;
  logic [7:0]         xor_eff_c;
`endif

  // Packet assembly: a timeout on this cycle restarts the packet at index 0
  always_comb begin
    tmo_hit_c  = (idx != '0) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
    idx_eff_c  = tmo_hit_c ? '0 : idx;
    last_c     = rx_valid && (idx_eff_c == IDX_W'(TOT - 1));
    pkt_next_c = pkt_buf;
    if (32'(idx_eff_c) < BYTES)
      pkt_next_c[32'(idx_eff_c)*8 +: 8] = rx_data;
    go_c = pkt_next_c[PKT_W-1];
`ifdef ORDER_CHECKSUM_EN
    xor_eff_c  = (idx_eff_c == '0) ? 8'h00 : xor_acc;
    pkt_done_c = last_c && (xor_eff_c == rx_data);
    chk_bad_c  = last_c && (xor_eff_c != rx_data);
`else
    pkt_done_c = last_c;
    chk_bad_c  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      tmo_cnt       <= '0;
      pkt_buf       <= '0;
      debug_command <= '0;
      err_cnt       <= 8'h00;
    end else begin
      if (rx_valid) begin
        idx     <= last_c ? '0 : idx_eff_c + IDX_W'(1);
        tmo_cnt <= '0;
        pkt_buf <= pkt_next_c;
      end else if (tmo_hit_c) begin
        idx     <= '0;
        tmo_cnt <= '0;
      end else if (idx != '0) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (pkt_done_c)
        debug_command <= pkt_next_c;
      if ((tmo_hit_c || chk_bad_c) && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef ORDER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)
      xor_acc <= 8'h00;
    else if (rx_valid)
      xor_acc <= xor_eff_c ^ rx_data;
  end
`endif

  // Order FIFO: a push into a full queue is only accepted when a pop frees a slot
  always_comb begin
    pop_c  = (state == D_IDLE) && (queue_level != '0);
    push_c = pkt_done_c && go_c && (!queue_full || pop_c);
    drop_c = pkt_done_c && go_c && queue_full && !pop_c;
    level_next_c = queue_level;
    if (push_c && !pop_c)
      level_next_c = queue_level + LVL_W'(1);
    else if (pop_c && !push_c)
      level_next_c = queue_level - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_c)
      mem[wr_ptr] <= pkt_next_c[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
      queue_full  <= 1'b0;
      drop_cnt    <= 8'h00;
    end else begin
      if (push_c)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)
        rd_ptr <= rd_ptr + PTR_W'(1);
      queue_level <= level_next_c;
      queue_full  <= (level_next_c == LVL_W'(DEPTH));
      if (drop_c && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Dispatch FSM: start pulse, two settle cycles, then wait for the bank to go idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= D_IDLE;
      settle_cnt <= 1'b0;
      disp_start <= 1'b0;
      disp_count <= '0;
      busy       <= 1'b0;
    end else begin
      disp_start <= 1'b0;
      case (state)
        D_IDLE: begin
          if (pop_c) begin
            disp_count <= mem[rd_ptr];
            disp_start <= 1'b1;
            busy       <= 1'b1;
            state      <= D_START;
          end
        end
        D_START: begin
          settle_cnt <= 1'b0;
          state      <= D_SETTLE;
        end
        D_SETTLE: begin
          settle_cnt <= ~settle_cnt;
          if (settle_cnt)
            state <= D_RUN;
        end
        D_RUN: begin
          if (disp_busy == '0) begin
            busy  <= 1'b0;
            state <= D_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snack_order_manager.sv
// Directed bench for snack_order_manager; short timeout keeps the run small.
module tb_snack_order_manager;

  localparam int unsigned T = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [4:0]  disp_busy;
  logic        disp_start;
  logic [14:0] disp_count;
  logic        busy;
  logic [2:0]  queue_level;
  logic        queue_full;
  logic [7:0]  drop_cnt;
  logic [7:0]  err_cnt;
  logic [15:0] debug_command;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int s0;
  logic [14:0] log_q[$];

  snack_order_manager #(.N_CH(5), .CNT_W(3), .DEPTH(4), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .disp_busy(disp_busy), .disp_start(disp_start), .disp_count(disp_count),
    .busy(busy), .queue_level(queue_level), .queue_full(queue_full),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt), .debug_command(debug_command)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && disp_start) begin
      start_cnt = start_cnt + 1;
      log_q.push_back(disp_count);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
`ifdef ORDER_CHECKSUM_EN
    send_byte(w[7:0] ^ w[15:8]);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; disp_busy = 5'h00;
    idle(3);
    check("rst_start", 32'(disp_start), 32'h0);
    check("rst_count", 32'(disp_count), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_level", 32'(queue_level), 32'h0);
    check("rst_full",  32'(queue_full), 32'h0);
    check("rst_drop",  32'(drop_cnt), 32'h0);
    check("rst_err",   32'(err_cnt), 32'h0);
    check("rst_dbg",   32'(debug_command), 32'h0);
    rst = 1'b0;
    idle(1);

    // Single GO order from idle: push, pop, then start pulse
    send_pkt(16'h8A53);
    check("go_dbg",    32'(debug_command), 32'h8A53);
    check("go_level1", 32'(queue_level), 32'h1);
    check("go_nostart", 32'(disp_start), 32'h0);
    idle(1);
    check("go_start",  32'(disp_start), 32'h1);
    check("go_count",  32'(disp_count), 32'h0A53);
    check("go_busy",   32'(busy), 32'h1);
    check("go_level0", 32'(queue_level), 32'h0);
    idle(1);
    check("go_pulse1", 32'(disp_start), 32'h0);
    idle(8);
    check("go_idle",   32'(busy), 32'h0);
    check("go_nstart", 32'(start_cnt), 32'd1);

    // GO=0 packet is reported but never queued
    send_pkt(16'h0A53);
    check("nogo_dbg",   32'(debug_command), 32'h0A53);
    check("nogo_level", 32'(queue_level), 32'h0);
    idle(8);
    check("nogo_nstart", 32'(start_cnt), 32'd1);

    // Six orders while the bank is busy: one in flight, four queued, one dropped
    disp_busy = 5'h1F;
    log_q.delete();
    for (int i = 1; i <= 6; i++) send_pkt(16'h8000 | 16'(i));
    check("fill_level", 32'(queue_level), 32'd4);
    check("fill_full",  32'(queue_full), 32'h1);
    check("fill_drop",  32'(drop_cnt), 32'd1);
    check("fill_count", 32'(disp_count), 32'h1);
    check("fill_busy",  32'(busy), 32'h1);
    disp_busy = 5'h00;
    idle(40);
    check("drain_nstart", 32'(start_cnt), 32'd6);
    check("drain_nlog",   32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) check("drain_order", 32'(log_q[i]), 32'(i + 1));
    check("drain_level", 32'(queue_level), 32'h0);
    check("drain_full",  32'(queue_full), 32'h0);
    check("drain_busy",  32'(busy), 32'h0);

    // Timeout: byte on the timeout cycle starts a fresh packet
    send_byte(8'h53);
    idle(T);
    send_pkt(16'h8011);
    check("tmo_err", 32'(err_cnt), 32'd1);
    check("tmo_dbg", 32'(debug_command), 32'h8011);
    idle(10);
    // One cycle short of the timeout still completes the packet
    send_byte(8'h22);
    idle(T - 1);
    send_byte(8'h00);
`ifdef ORDER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    check("tmo_edge_dbg", 32'(debug_command), 32'h0022);
    check("tmo_edge_err", 32'(err_cnt), 32'd1);
    send_byte(8'h33);
    idle(T + 3);
    check("tmo_idle_err", 32'(err_cnt), 32'd2);
    send_pkt(16'h0044);
    check("tmo_after_dbg", 32'(debug_command), 32'h0044);
    check("tmo_after_err", 32'(err_cnt), 32'd2);

`ifdef ORDER_CHECKSUM_EN
    send_byte(8'h53); send_byte(8'h8A); send_byte(8'hD9);
    check("cs_ok_dbg", 32'(debug_command), 32'h8A53);
    idle(10);
    s0 = start_cnt;
    send_byte(8'h11); send_byte(8'h80); send_byte(8'h00);
    check("cs_bad_err", 32'(err_cnt), 32'd3);
    check("cs_bad_dbg", 32'(debug_command), 32'h8A53);
    idle(8);
    check("cs_bad_nodisp", 32'(start_cnt), 32'(s0));
`endif

    // All-zero order takes the minimum path: START, 2x SETTLE, RUN, IDLE
    s0 = start_cnt;
    send_pkt(16'h8000);
    idle(1);
    check("zero_start", 32'(disp_start), 32'h1);
    check("zero_count", 32'(disp_count), 32'h0);
    idle(3);
    check("zero_busy_run", 32'(busy), 32'h1);
    idle(1);
    check("zero_busy_idle", 32'(busy), 32'h0);
    check("zero_nstart", 32'(start_cnt), 32'(s0 + 1));

    // Reset during D_RUN with two orders waiting
    disp_busy = 5'h1F;
    send_pkt(16'h8007);
    send_pkt(16'h8003);
    send_pkt(16'h8004);
    idle(5);
    check("prerst_level", 32'(queue_level), 32'd2);
    check("prerst_busy",  32'(busy), 32'h1);
    s0 = start_cnt;
    rst = 1'b1;
    idle(1);
    check("mrst_start", 32'(disp_start), 32'h0);
    check("mrst_count", 32'(disp_count), 32'h0);
    check("mrst_busy",  32'(busy), 32'h0);
    check("mrst_level", 32'(queue_level), 32'h0);
    check("mrst_full",  32'(queue_full), 32'h0);
    check("mrst_drop",  32'(drop_cnt), 32'h0);
    check("mrst_err",   32'(err_cnt), 32'h0);
    check("mrst_dbg",   32'(debug_command), 32'h0);
    rst = 1'b0;
    idle(5);
    disp_busy = 5'h00;
    idle(20);
    check("mrst_nostart", 32'(start_cnt), 32'(s0));
    check("mrst_level2",  32'(queue_level), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
